// File: rtl/mips_prog_loader_pkg.sv
// Shared definitions for the mips program loader: FSM states, word framing
// constants and the header word-count legality check.
package mips_prog_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CNT_LO = 3'd1,
    S_DATA   = 3'd2,
    S_CKSUM  = 3'd3,
    S_ARM    = 3'd4,
    S_RUN    = 3'd5,
    S_DONE   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  // A program must hold at least one word and fit in 2**addr_w words.
  function automatic logic count_ok(input logic [15:0] n, input int unsigned addr_w);
    return (n != 16'd0) && ({1'b0, n} <= (17'd1 << addr_w));
  endfunction

endpackage

// File: rtl/mips_prog_loader_if.sv
// Byte-stream valid/ready channel feeding the program loader.
interface mips_prog_loader_if;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/mips_prog_loader_b2w.sv
// Byte-to-word assembler: packs four stream bytes MSB first into a 32-bit
// word and flags the word on the fourth byte.
module byte_to_word_assembler
  import mips_prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  logic [1:0]  r_cnt;
  logic [23:0] r_shift;

  // Byte position counter and shift register; clear discards any partial word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (i_clear) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (i_byte_valid) begin
      r_cnt   <= r_cnt + 2'd1;
      r_shift <= {r_shift[15:0], i_byte};
    end
  end

  assign o_word_valid = i_byte_valid && !i_clear && (r_cnt == 2'(BYTES_PER_WORD - 1));
  assign o_word       = {r_shift, i_byte};

endmodule

// File: rtl/mips_prog_loader.sv
// Program loader for the mips core: takes a 16-bit word count, then N
// big-endian words, writes them to memory from address 0, then releases
// the core and reports completion when it halts.
// Optional feature macro: LOADER_CKSUM_EN (trailing XOR checksum byte).
module mips_prog_loader
  import mips_prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  mips_prog_loader_if.slave   s_if,
  input  logic                restart,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                cpu_run,
  input  logic                cpu_halted,
  output logic                busy,
  output logic                done,
  output logic                error
);

  state_t      r_state, w_next;
  logic [15:0] r_n;
  logic [15:0] r_word_idx;
  logic [15:0] w_n_hdr;
  logic        w_accept;
  logic        w_last_word;
  logic        w_word_valid;
  logic [31:0] w_word;
`ifdef LOADER_CKSUM_EN
  logic [7:0]  r_xor;
`endif

  // restart outranks a same-cycle byte, so that byte is never accepted.
  assign w_accept    = s_if.s_valid && s_if.s_ready && !restart;
  assign w_n_hdr     = {r_n[15:8], s_if.s_data};
  assign w_last_word = (r_word_idx == r_n - 16'd1);

  byte_to_word_assembler u_b2w (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (restart || (r_state == S_IDLE)),
    .i_byte_valid (w_accept && (r_state == S_DATA)),
    .i_byte       (s_if.s_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    if (restart) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (w_accept) w_next = S_CNT_LO;
        S_CNT_LO: if (w_accept) w_next = count_ok(w_n_hdr, ADDR_W) ? S_DATA : S_ERROR;
`ifdef LOADER_CKSUM_EN
        S_DATA:   if (w_word_valid && w_last_word) w_next = S_CKSUM;
        S_CKSUM:  if (w_accept) w_next = (r_xor == s_if.s_data) ? S_ARM : S_ERROR;
`else
        S_DATA:   if (w_word_valid && w_last_word) w_next = S_ARM;
`endif
        S_ARM:    w_next = S_RUN;
        S_RUN:    if (cpu_halted) w_next = S_DONE;
        S_DONE:   w_next = S_DONE;
        S_ERROR:  w_next = S_ERROR;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  // State-decoded outputs.
  always_comb begin
    s_if.s_ready = (r_state == S_IDLE) || (r_state == S_CNT_LO) ||
                   (r_state == S_DATA) || (r_state == S_CKSUM);
    busy         = (r_state == S_CNT_LO) || (r_state == S_DATA) || (r_state == S_CKSUM) ||
                   (r_state == S_ARM) || (r_state == S_RUN);
    done         = (r_state == S_DONE);
    error        = (r_state == S_ERROR);
  end

  // Header, word index, memory port and core-release registers.
  // cpu_run follows the RUN state one cycle late so it rises two edges after
  // the final stream byte (the ARM cycle lets the last write retire first).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_n        <= '0;
      r_word_idx <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_run    <= 1'b0;
    end else if (restart) begin
      r_n        <= '0;
      r_word_idx <= '0;
      mem_we     <= 1'b0;
      cpu_run    <= 1'b0;
    end else begin
      mem_we  <= w_word_valid;
      cpu_run <= (r_state == S_RUN) && !cpu_halted;
      if (w_accept && (r_state == S_IDLE))   r_n[15:8] <= s_if.s_data;
      if (w_accept && (r_state == S_CNT_LO)) r_n[7:0]  <= s_if.s_data;
      if (r_state == S_IDLE) begin
        r_word_idx <= '0;
      end else if (w_word_valid) begin
        mem_addr   <= r_word_idx[ADDR_W-1:0];
        mem_wdata  <= DATA_W'(w_word);
        r_word_idx <= r_word_idx + 16'd1;
      end
    end
  end

`ifdef LOADER_CKSUM_EN
  // Running XOR over payload bytes only; header bytes never reach DATA.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  r_xor <= '0;
    else if (restart || (r_state == S_IDLE))  r_xor <= '0;
    else if (w_accept && (r_state == S_DATA)) r_xor <= r_xor ^ s_if.s_data;
  end
`endif

endmodule

// File: tb/tb_mips_prog_loader.sv
module tb_mips_prog_loader;

  localparam int unsigned ADDR_W = 10;
`ifdef LOADER_CKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              restart = 1'b0;
  logic              cpu_halted = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_run, busy, done, error;

  mips_prog_loader_if bus();

  mips_prog_loader #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .s_if(bus.slave), .restart(restart),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_run(cpu_run), .cpu_halted(cpu_halted),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t         exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned last_acc_cyc = 0;
  int unsigned run_rise_cyc = 0;
  bit          run_seen = 1'b0;
  logic        prev_run = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe is matched against the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      if (mem_we) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr %0d data 0x%08h expected no write", mem_addr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          if (mem_addr !== e.addr || mem_wdata !== e.data) begin
            errors++;
            $display("FAIL write: got addr %0d data 0x%08h expected addr %0d data 0x%08h",
                     mem_addr, mem_wdata, e.addr, e.data);
          end
        end
      end
      if (cpu_run && !prev_run) run_rise_cyc = cyc;
      if (cpu_run) run_seen = 1'b1;
    end
    prev_run = cpu_run;
  end

  task automatic send_byte(input logic [7:0] b, input int unsigned gap_pct);
    int unsigned waits = 0;
    while (gap_pct != 0 && $urandom_range(99) < gap_pct) begin
      bus.s_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    while (!bus.s_ready && waits < 50) begin
      @(posedge clk); #1;
      waits++;
    end
    if (!bus.s_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got s_ready=0 for 50 cycles expected 1");
    end else begin
      @(posedge clk); #1;
      last_acc_cyc = cyc;
    end
    bus.s_valid = 1'b0;
  endtask

  // Reference model: word i lands at address i; header legality and checksum
  // outcome are derived from the count and the payload bytes.
  task automatic load(input logic [31:0] words[$], input logic [15:0] n,
                      input int unsigned gap, input bit bad_ck, output bit exp_err);
    logic [7:0] x;
    logic [7:0] b;
    bit ok;
    wr_t w;
    x  = 8'h00;
    ok = (n != 16'd0) && (int'(n) <= (1 << ADDR_W));
    send_byte(n[15:8], gap);
    send_byte(n[7:0], gap);
    if (ok) begin
      for (int i = 0; i < int'(n); i++) begin
        w.addr = ADDR_W'(i);
        w.data = words[i];
        exp_q.push_back(w);
        for (int j = 3; j >= 0; j--) begin
          b = words[i][8*j +: 8];
          x = x ^ b;
          send_byte(b, gap);
        end
      end
      if (CK_EN) send_byte(bad_ck ? (x ^ 8'h01) : x, gap);
    end
    exp_err = !ok || (CK_EN && bad_ck);
  endtask

  task automatic halt_after(input string name, input int unsigned dly);
    int unsigned w = 0;
    while (!cpu_run && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk({name, "_run_up"}, cpu_run, 1);
    repeat (dly) @(posedge clk);
    #1;
    cpu_halted = 1'b1;
    @(posedge clk); #1;
    cpu_halted = 1'b0;
    chk({name, "_run_delay"}, run_rise_cyc - last_acc_cyc, 2);
    chk({name, "_halt_run"}, cpu_run, 0);
    chk({name, "_halt_done"}, done, 1);
    chk({name, "_halt_busy"}, busy, 0);
    chk({name, "_halt_ready"}, bus.s_ready, 0);
  endtask

  task automatic do_restart(input string name, input bit with_byte);
    bus.s_valid = with_byte;
    bus.s_data  = 8'hAA;
    restart     = 1'b1;
    @(posedge clk); #1;
    restart     = 1'b0;
    bus.s_valid = 1'b0;
    chk({name, "_rs_busy"}, busy, 0);
    chk({name, "_rs_ready"}, bus.s_ready, 1);
    chk({name, "_rs_flags"}, {29'd0, done, error, cpu_run}, 0);
  endtask

  logic [31:0] words[$];
  logic [31:0] empty[$];
  bit          ee;

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", bus.s_ready, 1);
    chk("reset_outs", {27'd0, mem_we, cpu_run, busy, done, error}, 0);
    chk("reset_bus", {22'd0, mem_addr} | mem_wdata, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Two-word program, run, halt, stalled stream in DONE.
    words = '{32'h20220005, 32'hFC000000};
    load(words, 16'h0002, 0, 1'b0, ee);
    chk("t1_busy", busy, 1);
    halt_after("t1", 10);
    bus.s_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t2_hold_ready", bus.s_ready, 0);
    chk("t2_hold_done", done, 1);
    bus.s_valid = 1'b0;
    do_restart("t2", 1'b0);

    // Illegal headers; cpu_halted must be ignored in ERROR.
    run_seen = 1'b0;
    load(empty, 16'h0000, 0, 1'b0, ee);
    repeat (2) @(posedge clk);
    #1;
    chk("t3_n0_error", error, ee);
    cpu_halted = 1'b1;
    @(posedge clk); #1;
    cpu_halted = 1'b0;
    chk("t3_halt_ignored", {30'd0, done, error}, 1);
    do_restart("t3a", 1'b1);
    load(empty, 16'h0401, 0, 1'b0, ee);
    @(posedge clk); #1;
    chk("t3_big_error", error, ee);
    chk("t3_no_run", run_seen, 0);
    do_restart("t3b", 1'b0);

    // Largest legal program.
    words.delete();
    for (int i = 0; i < 1024; i++) words.push_back($urandom);
    load(words, 16'h0400, 0, 1'b0, ee);
    chk("t3_max_noerr", error, 0);
    halt_after("t3max", 3);
    do_restart("t3c", 1'b0);

    // Eight words with random gaps, then the same words back to back.
    words.delete();
    for (int i = 0; i < 8; i++) words.push_back($urandom);
    load(words, 16'h0008, 50, 1'b0, ee);
    halt_after("t4gap", 2);
    do_restart("t4a", 1'b0);
    load(words, 16'h0008, 0, 1'b0, ee);
    halt_after("t4b2b", 5);
    do_restart("t4b", 1'b0);

    // restart after 6 bytes, and after a partial word with a same-cycle byte.
    words = '{32'h11223344};
    send_byte(8'h00, 0); send_byte(8'h03, 0);
    exp_q.push_back('{addr: '0, data: 32'hDEADBEEF});
    send_byte(8'hDE, 0); send_byte(8'hAD, 0); send_byte(8'hBE, 0); send_byte(8'hEF, 0);
    @(posedge clk); #1;
    do_restart("t5a", 1'b0);
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'h55, 0); send_byte(8'h66, 0);
    do_restart("t5b", 1'b1);
    load(words, 16'h0001, 0, 1'b0, ee);
    halt_after("t5", 1);
    chk("t5_writes_left", exp_q.size(), 0);
    do_restart("t5c", 1'b0);

    // Corrupted checksum (only meaningful with the checksum feature).
    run_seen = 1'b0;
    words = '{32'hCAFEF00D, 32'h0BADC0DE};
    load(words, 16'h0002, 0, 1'b1, ee);
    repeat (4) @(posedge clk);
    #1;
    chk("t6_ck_error", error, ee);
    chk("t6_run_seen", run_seen, !ee);
    if (!ee) halt_after("t6", 1);
    do_restart("t6", 1'b0);

    // Asynchronous reset in the middle of DATA.
    send_byte(8'h00, 0); send_byte(8'h04, 0);
    exp_q.push_back('{addr: '0, data: 32'h01020304});
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
    send_byte(8'h05, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t7_rst_ready", bus.s_ready, 1);
    chk("t7_rst_outs", {27'd0, mem_we, cpu_run, busy, done, error}, 0);
    chk("t7_rst_bus", {22'd0, mem_addr} | mem_wdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    chk("final_writes_left", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
